serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub.sv | 115 +++++++++++
 tb/tb_serial_add_sub.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB first, through a
// ripple chain of full-adder cells, with valid/ready handshakes on operands and result.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_sub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_add_sub: DIGIT must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] a_sh, b_sh, res_nxt;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s_sl;

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);

    // Operands shift right each RUN cycle so the active slice is always the low DIGIT bits.
    assign c[0] = carry;
    fa_cell u_fa [DIGIT-1:0] (
        .a  (a_q[DIGIT-1:0]),
        .b  (b_q[DIGIT-1:0]),
        .ci (c[DIGIT-1:0]),
        .s  (s_sl),
        .co (c[DIGIT:1])
    );

    if (N == 1) begin : g_one
        assign a_sh    = a_q;
        assign b_sh    = b_q;
        assign res_nxt = s_sl;
    end else begin : g_multi
        // Partial result: completed slices enter at the top and drift down.
        logic [WIDTH-DIGIT-1:0] res_q;

        assign a_sh    = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
        assign b_sh    = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
        assign res_nxt = {s_sl, res_q};

        always_ff @(posedge clk) begin
            if (!rst && state == RUN)
                res_q <= res_nxt[WIDTH-1:DIGIT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= sub ? ~b : b;
                    carry <= sub;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_q   <= a_sh;
                    b_q   <= b_sh;
                    carry <= c[DIGIT];
                    if (cnt == CW'(N - 1)) begin
                        sum   <= res_nxt;
                        cout  <= c[DIGIT];
                        ovf   <= c[DIGIT] ^ c[DIGIT-1];
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: 32/4 instance plus 8/1 and 8/8 instances.

module tb_serial_add_sub;
    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        o;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t sb[$];

    logic        w_iv, w_ir, w_sub, w_ov, w_or, w_co, w_ovf;
    logic [31:0] w_a, w_b, w_sum;

    logic       s_iv[2], s_ir[2], s_sub[2], s_ov[2], s_or[2], s_co[2], s_ovf[2];
    logic [7:0] s_a[2], s_b[2], s_sum[2];

    serial_add_sub #(.WIDTH(32), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir), .a(w_a), .b(w_b),
        .sub(w_sub), .out_valid(w_ov), .out_ready(w_or), .sum(w_sum), .cout(w_co), .ovf(w_ovf)
    );

    for (genvar k = 0; k < 2; k++) begin : g_small
        serial_add_sub #(.WIDTH(8), .DIGIT(k == 0 ? 1 : 8)) u_dut (
            .clk(clk), .rst(rst), .in_valid(s_iv[k]), .in_ready(s_ir[k]), .a(s_a[k]), .b(s_b[k]),
            .sub(s_sub[k]), .out_valid(s_ov[k]), .out_ready(s_or[k]), .sum(s_sum[k]),
            .cout(s_co[k]), .ovf(s_ovf[k])
        );
    end

    // Reference: plain integer add of the (possibly inverted) operand, sign rule for overflow.
    function automatic res_t ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic s);
        logic [32:0] full;
        logic [31:0] m, aa, bb;
        res_t        r;
        m     = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa    = a & m;
        bb    = (s ? ~b : b) & m;
        full  = {1'b0, aa} + {1'b0, bb} + {32'b0, s};
        r.sum = full[31:0] & m;
        r.c   = full[w];
        r.o   = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
        return r;
    endfunction

    task automatic wide_send(input logic [31:0] a, input logic [31:0] b, input logic s,
                             input res_t e);
        @(negedge clk);
        w_a = a; w_b = b; w_sub = s; w_iv = 1'b1;
        n_cmp++;
        if (w_ir !== 1'b1) begin
            n_bad++; $display("FAIL wide_in_ready: got %b want 1", w_ir);
        end
        sb.push_back(e);
        @(negedge clk);
        w_iv = 1'b0;
    endtask

    task automatic wide_result(input string tag);
        int   lat = 0;
        res_t e, got;
        while (w_ov !== 1'b1 && lat < 64) begin
            @(negedge clk); lat++;
        end
        n_cmp++;
        if (lat != 8) begin
            n_bad++; $display("FAIL %s_latency: got %0d want 8", tag, lat);
        end
        e   = sb.pop_front();
        got = {w_sum, w_co, w_ovf};
        n_cmp++;
        if (got !== e) begin
            n_bad++; $display("FAIL %s: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                              tag, got.sum, got.c, got.o, e.sum, e.c, e.o);
        end
    endtask

    task automatic wide_ack();
        w_or = 1'b1;
        @(negedge clk);
        w_or = 1'b0;
    endtask

    task automatic small_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic s,
                            input res_t e);
        int   lat = 0;
        int   want_lat;
        res_t ex, got;
        want_lat = (k == 0) ? 8 : 1;
        @(negedge clk);
        s_a[k] = a; s_b[k] = b; s_sub[k] = s; s_iv[k] = 1'b1;
        n_cmp++;
        if (s_ir[k] !== 1'b1) begin
            n_bad++; $display("FAIL small%0d_in_ready: got %b want 1", k, s_ir[k]);
        end
        sb.push_back(e);
        @(negedge clk);
        s_iv[k] = 1'b0;
        while (s_ov[k] !== 1'b1 && lat < 64) begin
            @(negedge clk); lat++;
        end
        n_cmp++;
        if (lat != want_lat) begin
            n_bad++; $display("FAIL small%0d_latency: got %0d want %0d", k, lat, want_lat);
        end
        ex  = sb.pop_front();
        got = {24'b0, s_sum[k], s_co[k], s_ovf[k]};
        n_cmp++;
        if (got !== ex) begin
            n_bad++; $display("FAIL small%0d_result %h %s %h: got %h/%b/%b want %h/%b/%b",
                              k, a, s ? "-" : "+", b, got.sum, got.c, got.o, ex.sum, ex.c, ex.o);
        end
        s_or[k] = 1'b1;
        @(negedge clk);
        s_or[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (w_ir !== 1'b0 || w_ov !== 1'b0) begin
            n_bad++; $display("FAIL reset_initial: got ir=%b ov=%b want 0/0", w_ir, w_ov);
        end
        rst = 1'b0;
        wide_send(32'hC000_0000, 32'h8000_0000, 1'b0, '{32'h4000_0000, 1'b1, 1'b1});
        wide_result("reset_pre_op");
        // Sitting in DONE with a nonzero result; reset must clear everything.
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (w_ir !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", w_ir); end
        n_cmp++;
        if (w_ov !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", w_ov); end
        n_cmp++;
        if (w_sum !== 32'h0) begin n_bad++; $display("FAIL reset_sum: got %h want 0", w_sum); end
        n_cmp++;
        if (w_co !== 1'b0 || w_ovf !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got c=%b o=%b want 0/0", w_co, w_ovf);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (w_ir !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", w_ir); end
    endtask

    task automatic test_wide_vectors();
        wide_send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0});
        wide_result("add_wrap");   wide_ack();
        wide_send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1});
        wide_result("add_ovf");    wide_ack();
        wide_send(32'd5, 32'd7, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0});
        wide_result("sub_5_7");    wide_ack();
        wide_send(32'd7, 32'd5, 1'b1, '{32'h0000_0002, 1'b1, 1'b0});
        wide_result("sub_7_5");    wide_ack();
        wide_send(32'h8000_0000, 32'd1, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1});
        wide_result("sub_min_1");  wide_ack();
    endtask

    task automatic test_wide_random();
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 30; i++) begin
            a = $urandom(); b = $urandom(); s = 1'($urandom_range(0, 1));
            wide_send(a, b, s, ref_op(32, a, b, s));
            wide_result("wide_rand");
            wide_ack();
        end
    endtask

    task automatic test_back_to_back();
        res_t snap;
        wide_send(32'h1234_5678, 32'h0FED_CBA9, 1'b0, ref_op(32, 32'h1234_5678, 32'h0FED_CBA9, 1'b0));
        wide_result("bp_first");
        snap = {w_sum, w_co, w_ovf};
        w_a = 32'hDEAD_BEEF; w_b = 32'h0000_1111; w_sub = 1'b1; w_iv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({w_sum, w_co, w_ovf} !== snap || w_ov !== 1'b1 || w_ir !== 1'b0) begin
                n_bad++; $display("FAIL bp_stall%0d: got %h ov=%b ir=%b want %h ov=1 ir=0",
                                  i, {w_sum, w_co, w_ovf}, w_ov, w_ir, snap);
            end
        end
        sb.push_back(ref_op(32, 32'hDEAD_BEEF, 32'h0000_1111, 1'b1));
        wide_ack();
        n_cmp++;
        if (w_ir !== 1'b1) begin n_bad++; $display("FAIL bp_idle_ready: got %b want 1", w_ir); end
        @(negedge clk);
        w_iv = 1'b0;
        n_cmp++;
        if (w_ir !== 1'b0) begin n_bad++; $display("FAIL bp_accepted: got ir=%b want 0", w_ir); end
        wide_result("bp_second");
        wide_ack();
    endtask

    task automatic test_reset_mid_run();
        int   seen = 0;
        res_t dropped;
        wide_send(32'h0000_00FF, 32'h0000_0001, 1'b0, ref_op(32, 32'h0000_00FF, 32'h0000_0001, 1'b0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dropped = sb.pop_front();
        for (int i = 0; i < 20; i++) begin
            #1;
            if (w_ov === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL midrun_no_result: got %0d valid cycles want 0 (dropped %h)",
                              seen, dropped.sum);
        end
        n_cmp++;
        if (w_ir !== 1'b1) begin n_bad++; $display("FAIL midrun_idle: got ir=%b want 1", w_ir); end
        wide_send(32'h0000_0010, 32'h0000_0020, 1'b0, '{32'h0000_0030, 1'b0, 1'b0});
        wide_result("midrun_recover");
        wide_ack();
    endtask

    task automatic test_small(input int k);
        logic [7:0] cv[8];
        logic [7:0] a, b;
        logic       s;
        cv = '{8'h00, 8'h01, 8'h05, 8'h07, 8'h7F, 8'h80, 8'hFE, 8'hFF};
        small_op(k, 8'hFF, 8'h01, 1'b0, '{32'h00, 1'b1, 1'b0});
        small_op(k, 8'h7F, 8'h01, 1'b0, '{32'h80, 1'b0, 1'b1});
        small_op(k, 8'h05, 8'h07, 1'b1, '{32'hFE, 1'b0, 1'b0});
        small_op(k, 8'h07, 8'h05, 1'b1, '{32'h02, 1'b1, 1'b0});
        small_op(k, 8'h80, 8'h01, 1'b1, '{32'h7F, 1'b1, 1'b1});
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                for (int m = 0; m < 2; m++)
                    small_op(k, cv[i], cv[j], 1'(m), ref_op(8, {24'b0, cv[i]}, {24'b0, cv[j]}, 1'(m)));
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); s = 1'($urandom_range(0, 1));
            small_op(k, a, b, s, ref_op(8, {24'b0, a}, {24'b0, b}, s));
        end
    endtask

    initial begin
        w_iv = 1'b0; w_or = 1'b0; w_sub = 1'b0; w_a = '0; w_b = '0;
        for (int k = 0; k < 2; k++) begin
            s_iv[k] = 1'b0; s_or[k] = 1'b0; s_sub[k] = 1'b0; s_a[k] = '0; s_b[k] = '0;
        end
        test_reset();
        test_wide_vectors();
        test_wide_random();
        test_back_to_back();
        test_reset_mid_run();
        test_small(0);
        test_small(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
